div: RTL and testbench
======================

Name: div

Overview:
- Iterative sequential integer divider, the inverse companion to the team's mult/multu units. Uses the same start/done handshake, so ALU control can drive multiply and divide the same way.
- Restoring radix-2 algorithm, one quotient bit per clock.
- Signed or unsigned operation, selected per operation by is_signed.
- Produces quotient and remainder for the datapath's HI/LO-style result registers.

Parameters:
- WIDTH, 32, operand and result width in bits.
- CNT_W, 5, iteration counter width; must satisfy 2**CNT_W == WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- a  input  WIDTH  dividend; sampled only on the start edge.
- b  input  WIDTH  divisor; sampled only on the start edge.
- is_signed  input  1  1 = two's-complement divide, 0 = unsigned; sampled on the start edge.
- doDiv  input  1  start request; level-sampled.
- quo  output  WIDTH  quotient.
- rem  output  WIDTH  remainder.
- div_done  output  1  result valid; held until next start or reset.
- div_zero  output  1  divisor was zero for the held result.
- busy  output  1  high in RUN and FIX.

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset: state IDLE; quo=0, rem=0, div_done=0, div_zero=0, busy=0; counter=0. Reset mid-operation aborts the operation with no partial result exposed.
- States: IDLE, RUN, FIX, DONE.
- Start (IDLE or DONE, doDiv=1 at edge N):
  - latch |a|, |b| (magnitude only if is_signed, else raw), sign of quotient (a[W-1]^b[W-1])&is_signed, sign of remainder a[W-1]&is_signed, and a zero flag (b==0);
  - clear partial remainder; counter=0; div_done<=0; state RUN.
- RUN, edges N+1..N+WIDTH, one iteration per edge:
  - shift {prem,dividend} left 1; trial = prem - divisor (WIDTH+1 bits);
  - if trial non-negative: prem=trial, new quotient LSB=1; else keep prem, LSB=0;
  - counter increments; at counter==WIDTH-1 go to FIX.
- FIX, edge N+WIDTH+1:
  - quo = negate-if-quotient-sign(raw quotient); rem = negate-if-remainder-sign(prem).
  - Divide by zero overrides: quo = all ones; rem = a (original, unsigned/signed alike); div_zero=1.
  - Signed overflow (0x80000000 / -1): quo=0x80000000, rem=0 falls out naturally; no flag.
  - div_done<=1; state DONE.
- Latency: fixed WIDTH+1 = 33 cycles from the start edge to div_done high, including divide by zero.
- doDiv while busy: ignored. Operands may change freely after the start edge.
- DONE: outputs held stable. doDiv=1 restarts per the start rule (div_done drops next edge). doDiv held high continuously re-launches each time DONE is reached.
- quo/rem are registered; they change only at FIX or reset.
- Widths: unsigned WIDTH-bit magnitudes (|0x80000000| = 0x80000000). The subtractor is WIDTH+1 bits, so no overflow is possible.

Decomposition:
- Package div_pkg holds:
  - state enum {IDLE,RUN,FIX,DONE};
  - WIDTH/CNT_W defaults;
  - helper function for conditional two's-complement negation.
- Natural sub-module: div_step, a combinational single restoring iteration. Inputs prem, next dividend bit, divisor; outputs new prem and quotient bit. Instanced once in div.

Test Plan (period 4, doDiv pulsed one cycle after reset release, results checked at div_done):
- Unsigned a=0x17, b=0x3 -> quo=0x7, rem=0x2, div_zero=0, div_done exactly 33 cycles after start edge.
- Signed a=0xFFFFFFE9 (-23), b=0x3 -> quo=0xFFFFFFF9 (-7), rem=0xFFFFFFFE (-2). Unsigned same operands -> quo=0x5555554D, rem=0x2.
- Divide by zero, a=0x69, b=0 (signed and unsigned) -> quo=0xFFFFFFFF, rem=0x69, div_zero=1, latency still 33.
- Signed a=0x80000000, b=0xFFFFFFFF -> quo=0x80000000, rem=0. Unsigned a=0xFFFFFFFF, b=0xFFFFFFFF -> quo=1, rem=0.
- doDiv re-pulsed at cycle 10 of a run with new operands -> ignored, first result unchanged. Restart from DONE -> div_done drops next edge, new result after 33 cycles.
- reset asserted at cycle 15 of a run -> next edge all outputs 0, busy=0. Fresh start afterwards gives a correct result.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and helpers for the iterative restoring divider.
package div_pkg;

    localparam int unsigned DIV_WIDTH = 32;
    localparam int unsigned DIV_CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Two's-complement negation when neg is set, pass-through otherwise.
    function automatic logic [DIV_WIDTH-1:0] neg_if(input logic [DIV_WIDTH-1:0] v,
                                                    input logic                 neg);
        return neg ? (~v + DIV_WIDTH'(1)) : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift in a dividend bit, trial-subtract.
module div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] prem,
    input  logic             dvd_bit,
    input  logic [WIDTH-1:0] dvsr,
    output logic [WIDTH-1:0] prem_next,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // prem < dvsr always holds, so the shifted value fits in WIDTH+1 bits and
    // the trial result is non-negative exactly when shifted >= dvsr.
    always_comb begin
        shifted   = {prem, dvd_bit};
        trial     = shifted - {1'b0, dvsr};
        q_bit     = (shifted >= {1'b0, dvsr});
        prem_next = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/div.sv
// Iterative signed/unsigned radix-2 restoring divider with start/done handshake.
module div
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH,
    parameter int unsigned CNT_W = DIV_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    input  logic             doDiv,
    output logic [WIDTH-1:0] quo,
    output logic [WIDTH-1:0] rem,
    output logic             div_done,
    output logic             div_zero,
    output logic             busy
);

    state_t state, state_next;

    logic [WIDTH-1:0] prem;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvsr;
    logic [WIDTH-1:0] a_q;
    logic             q_sign;
    logic             r_sign;
    logic             zero_q;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH-1:0] step_prem;
    logic             step_q;
    logic             last_iter;

    div_step #(.WIDTH(WIDTH)) u_step (
        .prem      (prem),
        .dvd_bit   (dvd[WIDTH-1]),
        .dvsr      (dvsr),
        .prem_next (step_prem),
        .q_bit     (step_q)
    );

    assign last_iter = (cnt == CNT_W'(WIDTH - 1));
    assign busy      = (state == RUN) || (state == FIX);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: if (doDiv) state_next = RUN;
            RUN:        if (last_iter) state_next = FIX;
            FIX:        state_next = DONE;
            default:    state_next = IDLE;
        endcase
    end

    // The dividend register doubles as the quotient: result bits shift in at the LSB.
    always_ff @(posedge clk) begin
        if (reset) begin
            prem     <= '0;
            dvd      <= '0;
            dvsr     <= '0;
            a_q      <= '0;
            q_sign   <= 1'b0;
            r_sign   <= 1'b0;
            zero_q   <= 1'b0;
            cnt      <= '0;
            quo      <= '0;
            rem      <= '0;
            div_done <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (doDiv) begin
                        prem     <= '0;
                        dvd      <= neg_if(a, is_signed & a[WIDTH-1]);
                        dvsr     <= neg_if(b, is_signed & b[WIDTH-1]);
                        a_q      <= a;
                        q_sign   <= (a[WIDTH-1] ^ b[WIDTH-1]) & is_signed;
                        r_sign   <= a[WIDTH-1] & is_signed;
                        zero_q   <= (b == '0);
                        cnt      <= '0;
                        div_done <= 1'b0;
                    end
                end
                RUN: begin
                    prem <= step_prem;
                    dvd  <= {dvd[WIDTH-2:0], step_q};
                    cnt  <= cnt + CNT_W'(1);
                end
                FIX: begin
                    quo      <= zero_q ? '1  : neg_if(dvd, q_sign);
                    rem      <= zero_q ? a_q : neg_if(prem, r_sign);
                    div_zero <= zero_q;
                    div_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div.sv
// Directed, table-driven bench for the iterative divider.
module tb_div;

    logic        clk;
    logic        reset;
    logic [31:0] a;
    logic [31:0] b;
    logic        is_signed;
    logic        doDiv;
    logic [31:0] quo;
    logic [31:0] rem;
    logic        div_done;
    logic        div_zero;
    logic        busy;

    int checks = 0;
    int errors = 0;

    div #(.WIDTH(32), .CNT_W(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .a         (a),
        .b         (b),
        .is_signed (is_signed),
        .doDiv     (doDiv),
        .quo       (quo),
        .rem       (rem),
        .div_done  (div_done),
        .div_zero  (div_zero),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #2 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [31:0] quo;
        logic [31:0] rem;
        logic        zero;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Launch one divide and wait for div_done. A doDiv pulse with junk operands
    // is injected pulse_at cycles after the start edge (negative = never).
    task automatic do_op(input logic [31:0] va, input logic [31:0] vb, input logic vs,
                         input int pulse_at, output int lat);
        @(negedge clk);
        a = va; b = vb; is_signed = vs; doDiv = 1'b1;
        @(posedge clk);
        #1;
        doDiv = 1'b0;
        a = 32'hDEAD_BEEF; b = 32'h0000_0001; is_signed = ~vs;
        lat = 0;
        chk("done_drop", {31'b0, div_done}, 32'd0);
        while (!div_done && lat < 100) begin
            if (lat == pulse_at) begin
                doDiv = 1'b1; a = 32'h0000_0007; b = 32'h0000_0002;
            end
            @(posedge clk);
            #1;
            doDiv = 1'b0;
            lat++;
            if (lat == 5) chk("busy_run", {31'b0, busy}, 32'd1);
        end
    endtask

    int lat;

    initial begin
        vecs[0] = '{32'h0000_0017, 32'h0000_0003, 1'b0, 32'h0000_0007, 32'h0000_0002, 1'b0};
        vecs[1] = '{32'hFFFF_FFE9, 32'h0000_0003, 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b0};
        vecs[2] = '{32'hFFFF_FFE9, 32'h0000_0003, 1'b0, 32'h5555_554D, 32'h0000_0002, 1'b0};
        vecs[3] = '{32'h0000_0069, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 32'h0000_0069, 1'b1};
        vecs[4] = '{32'h0000_0069, 32'h0000_0000, 1'b0, 32'hFFFF_FFFF, 32'h0000_0069, 1'b1};
        vecs[5] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'h0000_0000, 1'b0};
        vecs[6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0000_0001, 32'h0000_0000, 1'b0};
        vecs[7] = '{32'h0000_0017, 32'hFFFF_FFFD, 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0};
        vecs[8] = '{32'hFFFF_FFE9, 32'hFFFF_FFFD, 1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0};
        vecs[9] = '{32'h0000_0005, 32'h0000_000A, 1'b0, 32'h0000_0000, 32'h0000_0005, 1'b0};

        reset = 1'b1; a = '0; b = '0; is_signed = 1'b0; doDiv = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_quo", quo, 32'd0);
        chk("rst_rem", rem, 32'd0);
        chk("rst_done", {31'b0, div_done}, 32'd0);
        chk("rst_zero", {31'b0, div_zero}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].s, -1, lat);
            chk($sformatf("v%0d_lat", i), lat, 32'd33);
            chk($sformatf("v%0d_quo", i), quo, vecs[i].quo);
            chk($sformatf("v%0d_rem", i), rem, vecs[i].rem);
            chk($sformatf("v%0d_zero", i), {31'b0, div_zero}, {31'b0, vecs[i].zero});
            chk($sformatf("v%0d_busy", i), {31'b0, busy}, 32'd0);
        end

        // Start request while busy must be ignored.
        do_op(32'd1000, 32'd10, 1'b0, 10, lat);
        chk("ign_lat", lat, 32'd33);
        chk("ign_quo", quo, 32'd100);
        chk("ign_rem", rem, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("ign_hold_done", {31'b0, div_done}, 32'd1);
        chk("ign_hold_quo", quo, 32'd100);

        // Restart straight from DONE.
        do_op(32'd100, 32'd7, 1'b0, -1, lat);
        chk("rs_lat", lat, 32'd33);
        chk("rs_quo", quo, 32'd14);
        chk("rs_rem", rem, 32'd2);

        // Reset in the middle of a run.
        @(negedge clk);
        a = 32'd50; b = 32'd0; is_signed = 1'b0; doDiv = 1'b1;
        @(posedge clk);
        #1;
        doDiv = 1'b0;
        repeat (14) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("mrst_quo", quo, 32'd0);
        chk("mrst_rem", rem, 32'd0);
        chk("mrst_done", {31'b0, div_done}, 32'd0);
        chk("mrst_zero", {31'b0, div_zero}, 32'd0);
        chk("mrst_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk("mrst_idle_done", {31'b0, div_done}, 32'd0);

        do_op(32'hFFFF_FF9C, 32'd7, 1'b1, -1, lat);
        chk("post_lat", lat, 32'd33);
        chk("post_quo", quo, 32'hFFFF_FFF2);
        chk("post_rem", rem, 32'hFFFF_FFFE);
        chk("post_zero", {31'b0, div_zero}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
